pc_branch_unit: RTL

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

---
 rtl/pc_branch_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/pc_branch_unit.sv
// Program counter with PC-relative branch target generation and registered ALU flags.
// pc_valid rises on the first edge after reset; PC advancement starts one edge later.
module pc_branch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          PC_W     = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic            BrTaken,
    input  logic            UncondBr,
    input  logic            writeEnable,
    input  logic            zero,
    input  logic            negative,
    input  logic            overflow,
    input  logic            carry_out,
    input  logic            stall,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            flag_z,
    output logic            flag_n,
    output logic            flag_v,
    output logic            flag_c,
    output logic            blt_taken,
    output logic            pc_valid
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      flags_q, flags_d;
    logic            pc_valid_q, pc_valid_d;

    logic [PC_W-1:0] cond_off;
    logic [PC_W-1:0] uncond_off;
    logic [PC_W-1:0] sel_off;
    logic [PC_W-1:0] br_target;
    logic            unused_opcode;

    // Opcode bits are decoded elsewhere; only the offset fields matter here.
    assign unused_opcode = ^instruction[31:26];

    assign cond_off   = {{(PC_W-19){instruction[23]}}, instruction[23:5]};
    assign uncond_off = {{(PC_W-26){instruction[25]}}, instruction[25:0]};

    always_comb begin
        pc_plus4   = pc_q + PC_W'(4);
        sel_off    = cond_off;
        br_target  = pc_plus4;
        pc_d       = pc_q;
        flags_d    = flags_q;
        pc_valid_d = 1'b1;

        // UncondBr is only consulted under BrTaken so an unknown select cannot reach pc.
        if (BrTaken) begin
            sel_off   = UncondBr ? uncond_off : cond_off;
            br_target = pc_q + {sel_off[PC_W-3:0], 2'b00};
        end

        if (!stall && pc_valid_q) begin
            pc_d = BrTaken ? br_target : pc_plus4;
            if (writeEnable) begin
                flags_d = {zero, negative, overflow, carry_out};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC[PC_W-1:0];
            flags_q    <= 4'b0000;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            flags_q    <= flags_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    assign pc        = pc_q;
    assign pc_valid  = pc_valid_q;
    assign flag_z    = flags_q[3];
    assign flag_n    = flags_q[2];
    assign flag_v    = flags_q[1];
    assign flag_c    = flags_q[0];
    assign blt_taken = flags_q[2] ^ flags_q[1];

endmodule
